// File: rtl/program_loader.sv
// program_loader: assembles big-endian 32-bit words from a UART byte stream into
// data memory, then (after an all-ones delimiter word) into instruction memory,
// and finally releases the CPU (cpu_run) on START_EXEC.
// Latency: a word is written one cycle after its 4th byte; echo byte appears one
// cycle after acceptance. Backpressure: none on rx; tx echo holds until tx_ready,
// a newer byte overwrites a pending one and sets echo_ovf.
// Ports: CLK, INITIALIZE (sync active-high reset), rx_valid/rx_data (byte in),
//   START_EXEC (run request), dmem_* / imem_* (memory write ports), cpu_run,
//   inst_count, load_err, tx_valid/tx_data/tx_ready (echo), echo_ovf.
// Build option: define LOADER_ECHO_EN to enable the byte echo path; otherwise
//   tx_valid, tx_data and echo_ovf are tied to 0 and tx_ready is ignored.
module program_loader #(
  parameter int DADDR_W = 10,
  parameter int IADDR_W = 12
) (
  input  logic               CLK,
  input  logic               INITIALIZE,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               START_EXEC,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_run,
  output logic [IADDR_W:0]   inst_count,
  output logic               load_err,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               echo_ovf
);

  typedef enum logic [1:0] {
    LOAD_DATA = 2'd0,
    LOAD_INST = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [DADDR_W-1:0] DPTR_ONE = 1;
  localparam logic [IADDR_W-1:0] IPTR_ONE = 1;
  localparam logic [IADDR_W:0]   ICNT_ONE = 1;
  localparam logic [IADDR_W:0]   ICNT_MAX = {1'b1, {IADDR_W{1'b0}}};

  state_t             state_q;
  logic [1:0]         byte_cnt_q;
  logic [23:0]        word_q;       // first three bytes of the word in flight
  logic [DADDR_W-1:0] dptr_q;
  logic [IADDR_W-1:0] iptr_q;
  logic               dfull_q;      // last data address has been written
  logic               ifull_q;      // last instruction address has been written
  logic               run_pend_q;   // START_EXEC met a 4th byte: finish the write, then RUN

  logic               dmem_we_q;
  logic [DADDR_W-1:0] dmem_addr_q;
  logic [31:0]        dmem_wdata_q;
  logic               imem_we_q;
  logic [IADDR_W-1:0] imem_addr_q;
  logic [31:0]        imem_wdata_q;
  logic               cpu_run_q;
  logic [IADDR_W:0]   inst_count_q;
  logic               load_err_q;

  // Byte acceptance and word assembly.
  logic        loading_d;
  logic        byte_acc_d;
  logic        word_done_d;
  logic [31:0] word_d;
  logic        is_delim_d;

  assign loading_d   = (state_q != RUN) && !run_pend_q;
  assign byte_acc_d  = loading_d && rx_valid;
  assign word_done_d = byte_acc_d && (byte_cnt_q == 2'd3);
  assign word_d      = {word_q, rx_data};
  assign is_delim_d  = (word_d == 32'hFFFF_FFFF);

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      state_q      <= LOAD_DATA;
      byte_cnt_q   <= 2'd0;
      word_q       <= 24'd0;
      dptr_q       <= '0;
      iptr_q       <= '0;
      dfull_q      <= 1'b0;
      ifull_q      <= 1'b0;
      run_pend_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_run_q    <= 1'b0;
      inst_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses.
      dmem_we_q <= 1'b0;
      imem_we_q <= 1'b0;

      case (state_q)
        LOAD_DATA: begin
          // START_EXEC has no effect until the delimiter has been seen.
          if (byte_acc_d) begin
            if (!word_done_d) begin
              word_q     <= {word_q[15:0], rx_data};
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end else begin
              byte_cnt_q <= 2'd0;
              if (is_delim_d) begin
                state_q <= LOAD_INST;
                iptr_q  <= '0;
                ifull_q <= 1'b0;
              end else if (dfull_q) begin
                load_err_q <= 1'b1;
              end else begin
                dmem_we_q    <= 1'b1;
                dmem_addr_q  <= dptr_q;
                dmem_wdata_q <= word_d;
                if (&dptr_q) dfull_q <= 1'b1;
                else         dptr_q  <= dptr_q + DPTR_ONE;
              end
            end
          end
        end

        LOAD_INST: begin
          if (run_pend_q) begin
            // The final write pulse is on the outputs this cycle; RUN follows.
            run_pend_q <= 1'b0;
            state_q    <= RUN;
            cpu_run_q  <= 1'b1;
          end else begin
            if (byte_acc_d) begin
              if (!word_done_d) begin
                word_q     <= {word_q[15:0], rx_data};
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end else begin
                byte_cnt_q <= 2'd0;
                if (ifull_q) begin
                  load_err_q <= 1'b1;
                end else begin
                  imem_we_q    <= 1'b1;
                  imem_addr_q  <= iptr_q;
                  imem_wdata_q <= word_d;
                  if (&iptr_q) ifull_q <= 1'b1;
                  else         iptr_q  <= iptr_q + IPTR_ONE;
                  if (inst_count_q != ICNT_MAX) inst_count_q <= inst_count_q + ICNT_ONE;
                end
              end
            end
            if (START_EXEC) begin
              // A partial word is discarded; a completing word is still written.
              byte_cnt_q <= 2'd0;
              if (word_done_d) begin
                run_pend_q <= 1'b1;
              end else begin
                state_q   <= RUN;
                cpu_run_q <= 1'b1;
              end
            end
          end
        end

        RUN: begin
          // Only INITIALIZE leaves RUN; the UART belongs to the CPU now.
          cpu_run_q <= 1'b1;
        end

        default: begin
          state_q   <= LOAD_DATA;
          cpu_run_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign inst_count = inst_count_q;
  assign load_err   = load_err_q;

`ifdef LOADER_ECHO_EN
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       echo_ovf_q;

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      echo_ovf_q <= 1'b0;
    end else if (byte_acc_d) begin
      // A pending byte not yet taken is lost to the newer one.
      if (tx_valid_q && !tx_ready) echo_ovf_q <= 1'b1;
      tx_valid_q <= 1'b1;
      tx_data_q  <= rx_data;
    end else if (tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign echo_ovf = echo_ovf_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;

  assign tx_valid = 1'b0;
  assign tx_data  = 8'd0;
  assign echo_ovf = 1'b0;
`endif

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter DADDR_W, default 10, data-memory word-address width.
REQ-002 The block SHALL have parameter IADDR_W, default 12, instruction-memory word-address width.
REQ-003 The block SHALL have ports: CLK  in  1  sole clock, all logic on posedge.
REQ-004 INITIALIZE  in  1  reset, synchronous, active-high.
REQ-005 rx_valid  in  1  one-cycle strobe, received UART byte available.
REQ-006 rx_data  in  8  received byte, valid with rx_valid.
REQ-007 START_EXEC  in  1  level request to begin execution.
REQ-008 dmem_we / dmem_addr / dmem_wdata  out  1 / DADDR_W / 32  data-memory write port.
REQ-009 imem_we / imem_addr / imem_wdata  out  1 / IADDR_W / 32  instruction-memory write port.
REQ-010 cpu_run  out  1  CPU may fetch; also hands UART to the CPU.
REQ-011 inst_count  out  IADDR_W+1  instruction words written.
REQ-012 load_err  out  1  sticky section-overflow flag.
REQ-013 tx_valid / tx_data / tx_ready  out / out / in  1 / 8 / 1  echo byte stream (see Configuration).
REQ-014 echo_ovf  out  1  sticky echo-overrun flag.

Function
REQ-015 States SHALL be LOAD_DATA, LOAD_INST, RUN; state after reset is LOAD_DATA.
REQ-016 In LOAD_* each rx_valid byte SHALL fill a big-endian word: 1st byte to [31:24], 4th to [7:0]; a 2-bit byte counter wraps 3->0.
REQ-017 On the 4th byte the word SHALL be written exactly one cycle later: 1-cycle we pulse, addr = section word pointer, which then increments.
REQ-018 In LOAD_DATA a complete word 0xFFFFFFFF SHALL NOT be written; instead the state SHALL become LOAD_INST with imem pointer 0.
REQ-019 In LOAD_INST 0xFFFFFFFF SHALL be written as an ordinary instruction.
REQ-020 A word arriving when its section pointer already equals 2^W-1 has been written (section full) SHALL be dropped and SHALL set load_err; pointers SHALL NOT wrap.
REQ-021 inst_count SHALL equal the number of imem writes performed, saturating at 2^IADDR_W.
REQ-022 START_EXEC SHALL be ignored in LOAD_DATA.
REQ-023 START_EXEC in LOAD_INST SHALL move to RUN next cycle, discarding any partial word (byte counter cleared).
REQ-024 If START_EXEC coincides with a 4th byte in LOAD_INST, that word SHALL still be written, then RUN.
REQ-025 cpu_run SHALL be 1 exactly in RUN; in RUN rx_valid SHALL be ignored and no memory writes SHALL occur.
REQ-026 RUN SHALL be left only by reset.
REQ-027 At most one of dmem_we, imem_we SHALL be high in any cycle.

Reset
REQ-028 INITIALIZE SHALL set state LOAD_DATA, pointers 0, byte counter 0, inst_count 0, all we 0, cpu_run 0, load_err 0, tx_valid 0, echo_ovf 0, data outputs 0.
REQ-029 INITIALIZE mid-word or in RUN SHALL abandon all progress; memory contents are not cleared; INITIALIZE has priority over every other input.

Configuration
REQ-030 With LOADER_ECHO_EN defined, each byte accepted in LOAD_* SHALL be registered into tx_data with tx_valid=1 next cycle, held until tx_ready.
REQ-031 With LOADER_ECHO_EN defined, a new byte arriving while tx_valid=1 and tx_ready=0 SHALL overwrite tx_data and set echo_ovf.
REQ-032 Without LOADER_ECHO_EN, tx_valid, tx_data and echo_ovf SHALL be constant 0 and tx_ready ignored.

Verification
REQ-033 Bytes 3F 80 00 00, FF FF FF FF, 4C 40 02 80 -> dmem[0]=0x3F800000, then imem[0]=0x4C400280, inst_count=1, no dmem write for delimiter.
REQ-034 Send 3 bytes of an instruction in LOAD_INST, pulse START_EXEC -> cpu_run=1 next cycle, no imem write, later bytes ignored.
REQ-035 START_EXEC asserted in LOAD_DATA -> state stays LOAD_DATA, cpu_run=0.
REQ-036 DADDR_W=2, send 5 data words -> dmem addr 0..3 written, 5th dropped, load_err=1.
REQ-037 INITIALIZE after 2 bytes, then 4 new bytes -> word formed from new bytes only, dmem_addr=0.
REQ-038 LOADER_ECHO_EN, tx_ready=0, two bytes 12 then 34 -> tx_data=0x34, echo_ovf=1; tx_ready=1 -> tx_valid drops.
